// File: rtl/reg_write_ctrl.sv
// Register-file write-port controller: post-reset zero sweep, then arbitration
// between in-order writebacks and a small FIFO of late dcache load returns.
module reg_write_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_valid_i,
  input  logic [AW-1:0]     wb_addr_i,
  input  logic [DW-1:0]     wb_data_i,
  input  logic              mem_valid_i,
  input  logic [AW-1:0]     mem_addr_i,
  input  logic [DW-1:0]     mem_data_i,
  output logic              mem_ready_o,
  output logic              regwrite_o,
  output logic [AW-1:0]     writeaddr_o,
  output logic [DW-1:0]     writedata_o,
  output logic              busy_o,
  output logic [2**AW-1:0]  pending_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [AW:0] SWEEP_END = {1'b1, {AW{1'b0}}};
  localparam logic [PW:0] FULL_CNT  = (PW+1)'(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;

  logic [AW-1:0]   q_addr [DEPTH];
  logic [DW-1:0]   q_data [DEPTH];
  logic [DEPTH-1:0] q_live, live_d, kill;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;

  logic            wb_acc, push, push_live, pop, full, empty;
  logic            we_d;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   data_d;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign busy_o      = (state_q == CLEAR);
  assign mem_ready_o = (state_q == RUN) && !full;

  // Register 0 is hardwired: requests to it are dropped before arbitration.
  assign wb_acc    = (state_q == RUN) && wb_valid_i && (wb_addr_i != '0);
  assign push      = mem_valid_i && mem_ready_o && (mem_addr_i != '0);
  assign push_live = !(wb_acc && (mem_addr_i == wb_addr_i));
  assign pop       = (state_q == RUN) && !wb_acc && !empty;

  // A writeback is younger than every queued load, so it kills same-address entries.
  always_comb begin
    kill   = '0;
    live_d = q_live;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i]   = wb_acc && q_live[i] && (q_addr[i] == wb_addr_i);
      live_d[i] = q_live[i] && !kill[i];
      if (pop && (PW'(i) == rd_ptr)) live_d[i] = 1'b0;
      if (push && (PW'(i) == wr_ptr)) live_d[i] = push_live;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (q_live[i]) pending_o[q_addr[i]] = 1'b1;
  end

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = writeaddr_o;
    data_d  = writedata_o;
    unique case (state_q)
      CLEAR: begin
        if (cnt_q == SWEEP_END) begin
          state_d = RUN;
        end else begin
          we_d   = 1'b1;
          addr_d = cnt_q[AW-1:0];
          data_d = '0;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (wb_acc) begin
          we_d   = 1'b1;
          addr_d = wb_addr_i;
          data_d = wb_data_i;
        end else if (pop && q_live[rd_ptr]) begin
          we_d   = 1'b1;
          addr_d = q_addr[rd_ptr];
          data_d = q_data[rd_ptr];
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      regwrite_o  <= 1'b0;
      writeaddr_o <= '0;
      writedata_o <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      q_live      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      regwrite_o  <= we_d;
      writeaddr_o <= addr_d;
      writedata_o <= data_d;
      q_live      <= live_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // NOTE: FIFO payload is not reset; only the live bits decide whether an entry counts.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_addr[wr_ptr] <= mem_addr_i;
      q_data[wr_ptr] <= mem_data_i;
    end
  end

endmodule

// File: doc/reg_write_ctrl.md
Name: reg_write_ctrl

Overview:
Drives the single write port of the 32x32 register file (regwrite/writeaddr/writedata). It sits between the writeback stage and the data cache and arbitrates two sources: in-order pipeline writebacks, and late load returns from the dcache after a miss. After reset it also sweeps every register to zero. The register file itself is unchanged and keeps sampling the write port on the falling clock edge.

Parameters:
DEPTH, 4, load-return FIFO entries (power of 2, >=2)
AW, 5, register address width
DW, 32, register data width

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset, synchronous, active-low
wb_valid_i  input  1  pipeline writeback request; never stalled
wb_addr_i  input  AW  writeback destination register
wb_data_i  input  DW  writeback data
mem_valid_i  input  1  dcache load-return request
mem_addr_i  input  AW  load destination register
mem_data_i  input  DW  load data
mem_ready_o  output  1  FIFO can accept; high when FIFO not full and not clearing
regwrite_o  output  1  register file write enable (registered)
writeaddr_o  output  AW  register file write address (registered)
writedata_o  output  DW  register file write data (registered)
busy_o  output  1  high during the post-reset clear sweep
pending_o  output  32  bit i high when a live FIFO entry targets register i (combinational from FIFO state)

Behaviour:
- Reset (rst_i=0 at a rising edge): FIFO emptied and all entries invalidated; state goes to CLEAR with sweep counter 0; regwrite_o=0, writeaddr_o=0, writedata_o=0, busy_o=1, pending_o=0. The same applies when reset is asserted mid-sweep or mid-drain.
- State CLEAR: one write per cycle of writedata_o=0 to addr 0,1,...,31. The counter is 6 bits, so there is no wrap. Sweep writes appear on regwrite_o in the 32 cycles after reset deasserts. Then state goes to RUN and busy_o falls.
- In CLEAR, mem_ready_o=0. wb_valid_i is ignored; the pipeline is held in stall by busy_o, and that is the integrator's responsibility.
- State RUN, one output write per cycle, registered, with 1-cycle latency from the accepting edge:
  - Priority 1: wb_valid_i with wb_addr_i!=0. Output next cycle is addr/data as given, regwrite_o=1.
  - Priority 2: otherwise, the FIFO head pops. If the head is live and its addr!=0, it is written. If the head is killed, regwrite_o=0 for that cycle and the pop still happens.
  - Otherwise regwrite_o=0. writeaddr_o and writedata_o hold their last values.
- A write to register 0 from either source is discarded at input: not written and not enqueued.
- Enqueue: mem_valid_i && mem_ready_o pushes {live=1, addr, data}. Enqueue and pop in the same cycle are both legal. On a full FIFO, mem_ready_o=0 and the dcache holds its request.
- Ordering rule: a wb write is younger than any queued load. An accepted wb write to register X kills every live FIFO entry with addr X in the same edge.
  - A load enqueued in the same cycle as a wb write to the same X is older, so it is also killed.
- pending_o is the OR of the one-hot addresses of live entries. Killed entries do not contribute.
- No back-to-back hazard handling beyond the above. Forwarding is outside this block.

Test Plan:
- Reset sweep: hold rst_i=0 for 2 cycles, then release. Required: 32 consecutive cycles of regwrite_o=1 with addr 0..31 and data 0; busy_o=1 throughout, then 0; mem_ready_o=0 during the sweep.
- Priority: in RUN, same cycle wb(5,0xAAAA0001) and mem(6,0xBBBB0002). Required: next cycle write r5=0xAAAA0001; cycle after, write r6=0xBBBB0002; pending_o bit 6 high for exactly 1 cycle.
- Full FIFO: with continuous wb to r1..r7 (DEPTH=4), push mem r8..r12. Required: the 4 pushes to r8..r11 are accepted and mem_ready_o drops; r12 is accepted only after the wb burst ends; loads drain in order r8,r9,r10,r11,r12.
- Kill: enqueue mem(9,0x11) while wb is busy, then wb(9,0x22). Required: r9 written with 0x22 only; when the dead entry pops, regwrite_o=0 for that cycle; pending_o[9] clears on the wb edge.
- r0 discard: wb(0,0xFFFFFFFF) and mem(0,0x1234). Required: no regwrite_o pulse, no enqueue, pending_o=0.
- Mid-operation reset: with 3 live entries, assert rst_i for 1 cycle. Required: FIFO empty, pending_o=0, sweep restarts at addr 0; no queued load is ever written.
